// File: rtl/uart_tx_if.sv
// Byte-to-serial handshake between a UART transmitter and its client.
// The client (master) offers a byte with a single-cycle trmt pulse.
// The transmitter (slave) drives the serial line TX and a sticky tx_done flag.
interface uart_tx_if;
    logic       trmt;     // single-cycle start request
    logic [7:0] tx_data;  // byte to send, sampled with trmt
    logic       TX;       // serial line, idle high
    logic       tx_done;  // sticky frame-complete flag

    modport master (
        output trmt,
        output tx_data,
        input  TX,
        input  tx_done
    );

    modport slave (
        input  trmt,
        input  tx_data,
        output TX,
        output tx_done
    );
endinterface : uart_tx_if

// File: rtl/uart_tx.sv
// UART transmitter: 8N1, LSB first, idle-high line, sticky tx_done.
// BAUD_DIV is the number of clk cycles per bit period (>= 2, fits 12 bits).
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the
// data MSB and the stop bit (11-bit frame). The build without the macro is
// the plain 8N1 frame that matches the existing receiver.
module uart_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

`ifdef UART_TX_PARITY_EN
    localparam int SR_W = 10;  // start + 8 data + parity
`else
    localparam int SR_W = 9;   // start + 8 data
`endif
    // The stop bit is shifted in as fill, so the frame has SR_W + 1 bits and
    // the final shift happens while bit_cnt still holds SR_W.
    localparam logic [3:0]  LAST_BIT  = 4'(SR_W);
    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

    typedef enum logic {
        IDLE,
        TRANSMITTING
    } state_t;

    state_t            state_q,     state_d;
    logic [SR_W-1:0]   shift_reg_q, shift_reg_d;
    logic [11:0]       baud_cnt_q,  baud_cnt_d;
    logic [3:0]        bit_cnt_q,   bit_cnt_d;
    logic              tx_done_q,   tx_done_d;

    logic              shift;
    logic [SR_W-1:0]   load_val;

    assign shift = (state_q == TRANSMITTING) && (baud_cnt_q == BAUD_LAST);

`ifdef UART_TX_PARITY_EN
    assign load_val = {^bus.tx_data, bus.tx_data, 1'b0};
`else
    assign load_val = {bus.tx_data, 1'b0};
`endif

    // TX comes straight from a flop so the line never glitches.
    assign bus.TX      = shift_reg_q[0];
    assign bus.tx_done = tx_done_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            shift_reg_q <= '1;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_done_q   <= tx_done_d;
        end
    end

    // Next-state and datapath update for the IDLE/TRANSMITTING FSM.
    always_comb begin
        // NOTE: every target gets a hold default first, so no latch is inferred.
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        tx_done_d   = tx_done_q;

        unique case (state_q)
            IDLE: begin
                if (bus.trmt) begin
                    shift_reg_d = load_val;
                    baud_cnt_d  = '0;
                    bit_cnt_d   = '0;
                    tx_done_d   = 1'b0;
                    state_d     = TRANSMITTING;
                end
            end

            TRANSMITTING: begin
                if (shift) begin
                    // Fill with 1s: the stop bit and idle level fall out for free.
                    shift_reg_d = {1'b1, shift_reg_q[SR_W-1:1]};
                    baud_cnt_d  = '0;
                    bit_cnt_d   = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_done_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 12'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule : uart_tx
